// File: rtl/axi_lite_ram_if.sv
// AXI4-lite bus bundle between the core's memory master and the RAM slave.
interface axi_lite_ram_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddress;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wrstrb;
  logic        bvalid;
  logic        bready;
  logic        bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddress;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rresp;

  modport slave (
    input  awvalid, awaddress, awprot, wvalid, wdata, wrstrb, bready,
           arvalid, araddress, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddress, awprot, wvalid, wdata, wrstrb, bready,
           arvalid, araddress, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI4-lite slave RAM: independent write (AW/W collect, commit, respond) and
// read (accept, respond) paths over a byte-maskable 32-bit word array.
module axi_lite_ram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  axi_lite_ram_if.slave bus
);
  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0] mem [DEPTH_WORDS];

  // live keeps every ready low until the first edge after reset release
  logic        live;
  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [31:0] aw_off, ar_off;
  logic        aw_in, ar_in;
  logic [IW-1:0] aw_idx, ar_idx;
  logic        awready, wready, bvalid, arready, rvalid;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        unused_prot;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside SPAN
  assign aw_off = aw_addr - BASE_ADDR;
  assign ar_off = bus.araddress - BASE_ADDR;
  assign aw_in  = {1'b0, aw_off} < SPAN;
  assign ar_in  = {1'b0, ar_off} < SPAN;
  assign aw_idx = aw_off[IW+1:2];
  assign ar_idx = ar_off[IW+1:2];
  assign unused_prot = ^{bus.awprot, bus.arprot};

  assign aw_hs = bus.awvalid && awready;
  assign w_hs  = bus.wvalid  && wready;
  assign b_hs  = bvalid      && bus.bready;
  assign ar_hs = bus.arvalid && arready;
  assign r_hs  = rvalid      && bus.rready;

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_COLLECT: begin
        awready = live && !aw_held;
        wready  = live && !w_held;
        if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
      end
      W_COMMIT: w_next = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (b_hs) w_next = W_COLLECT;
      end
      default: w_next = W_COLLECT;
    endcase
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (ar_hs) r_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_COLLECT;
      live    <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= 1'b0;
    end else begin
      w_state <= w_next;
      live    <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= bus.awaddress;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= bus.wdata;
        w_strb <= bus.wrstrb;
      end
      if (w_state == W_COMMIT) bresp_q <= !aw_in;
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Contents are deliberately not reset; a same-edge read sees the old word
  always_ff @(posedge clk) begin
    if (w_state == W_COMMIT && aw_in)
      for (int b = 0; b < 4; b++)
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata_q <= ar_in ? mem[ar_idx] : 32'h0;
        rresp_q <= !ar_in;
      end
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
endmodule
